// File: rtl/ysyx_22040237_ifu_pkg.sv
// Shared definitions for the instruction fetch unit: FSM encoding, reset PC,
// PC increment and the nop presented before the first fetch.
package ysyx_22040237_ifu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } ifu_state_e;

  localparam logic [63:0] IFU_RESET_PC = 64'h0000_0000_8000_0000;
  localparam logic [63:0] IFU_PC_STEP  = 64'd4;
  localparam logic [31:0] IFU_NOP      = 32'h0000_0013;

  // Word-aligns a jump target; all 64 bits are referenced on purpose.
  function automatic logic [63:0] align_pc(input logic [63:0] addr);
    return addr & ~64'h3;
  endfunction

endpackage

// File: rtl/ysyx_22040237_ifu.sv
// Instruction fetch unit: one outstanding word fetch, redirect with stale-response drop.
// Optional YSYX_22040237_IFU_MISALIGN_CHECK_EN adds a sticky misaligned-redirect trap.
module ysyx_22040237_ifu
  import ysyx_22040237_ifu_pkg::*;
#(
  parameter logic [63:0] RESET_PC = IFU_RESET_PC,
  parameter logic [63:0] PC_STEP  = IFU_PC_STEP
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
`ifdef YSYX_22040237_IFU_MISALIGN_CHECK_EN
  output logic        misalign_err,
`endif
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [63:0] pc,
  output logic [31:0] inst
);

  ifu_state_e  state_reg;
  logic [63:0] fetch_pc_reg;
  logic        drop_reg;
  logic        req_valid_reg;
  logic [63:0] req_addr_reg;
  logic        inst_valid_reg;
  logic [63:0] pc_reg;
  logic [31:0] inst_reg;

  logic [63:0] redirect_target;
  logic [63:0] seq_pc;
  logic [63:0] hold_next_pc;
  logic        halt;
  logic        misalign_trap;

`ifdef YSYX_22040237_IFU_MISALIGN_CHECK_EN
  logic misalign_err_reg;
  assign redirect_target = redirect_pc;
  assign halt            = misalign_err_reg;
  assign misalign_trap   = redirect_valid && (redirect_pc[1:0] != 2'b00) && (state_reg != IDLE);
  assign misalign_err    = misalign_err_reg;
`else
  assign redirect_target = align_pc(redirect_pc);
  assign halt            = 1'b0;
  assign misalign_trap   = 1'b0;
`endif

  assign seq_pc       = fetch_pc_reg + PC_STEP;
  assign hold_next_pc = redirect_valid ? redirect_target : seq_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      fetch_pc_reg   <= RESET_PC;
      drop_reg       <= 1'b0;
      req_valid_reg  <= 1'b0;
      req_addr_reg   <= RESET_PC;
      inst_valid_reg <= 1'b0;
      pc_reg         <= RESET_PC;
      inst_reg       <= IFU_NOP;
`ifdef YSYX_22040237_IFU_MISALIGN_CHECK_EN
      misalign_err_reg <= 1'b0;
`endif
    end else begin
      unique case (state_reg)
        IDLE: begin
          if (!halt) begin
            state_reg     <= REQ;
            req_valid_reg <= 1'b1;
            req_addr_reg  <= fetch_pc_reg;
          end
        end
        REQ: begin
          if (redirect_valid) begin
            fetch_pc_reg <= redirect_target;
            if (imem_req_ready) begin
              // The old address is already in flight; its response must be dropped.
              state_reg     <= WAIT;
              req_valid_reg <= 1'b0;
              drop_reg      <= 1'b1;
            end else begin
              req_addr_reg <= redirect_target;
            end
          end else if (imem_req_ready) begin
            state_reg     <= WAIT;
            req_valid_reg <= 1'b0;
          end
        end
        WAIT: begin
          if (imem_resp_valid) begin
            if (redirect_valid || drop_reg) begin
              drop_reg      <= 1'b0;
              state_reg     <= REQ;
              req_valid_reg <= 1'b1;
              req_addr_reg  <= redirect_valid ? redirect_target : fetch_pc_reg;
              if (redirect_valid) begin
                fetch_pc_reg <= redirect_target;
              end
            end else begin
              inst_reg       <= imem_resp_data;
              pc_reg         <= fetch_pc_reg;
              inst_valid_reg <= 1'b1;
              state_reg      <= HOLD;
            end
          end else if (redirect_valid) begin
            fetch_pc_reg <= redirect_target;
            drop_reg     <= 1'b1;
          end
        end
        HOLD: begin
          if (redirect_valid || inst_ready) begin
            fetch_pc_reg   <= hold_next_pc;
            inst_valid_reg <= 1'b0;
            state_reg      <= REQ;
            req_valid_reg  <= 1'b1;
            req_addr_reg   <= hold_next_pc;
          end
        end
      endcase

`ifdef YSYX_22040237_IFU_MISALIGN_CHECK_EN
      // A misaligned jump parks the fetcher for good; only reset recovers it.
      if (misalign_trap) begin
        misalign_err_reg <= 1'b1;
        state_reg        <= IDLE;
        req_valid_reg    <= 1'b0;
        inst_valid_reg   <= 1'b0;
        drop_reg         <= 1'b0;
      end
`else
      if (misalign_trap) begin
        state_reg <= IDLE;
      end
`endif
    end
  end

  assign imem_req_valid = req_valid_reg;
  assign imem_req_addr  = req_addr_reg;
  assign inst_valid     = inst_valid_reg;
  assign pc             = pc_reg;
  assign inst           = inst_reg;

endmodule

// File: tb/tb_ysyx_22040237_ifu.sv
// Scoreboard bench for ysyx_22040237_ifu: directed scenarios, then random memory
// timing, consume back-pressure and redirects against a program-order model.
`timescale 1ns/1ps
module tb_ysyx_22040237_ifu;

  localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;
`ifdef YSYX_22040237_IFU_MISALIGN_CHECK_EN
  localparam logic [63:0] LOW_MASK = 64'hC;
`else
  localparam logic [63:0] LOW_MASK = 64'hF;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = 64'h0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = 32'h0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [63:0] pc;
  logic [31:0] inst;
`ifdef YSYX_22040237_IFU_MISALIGN_CHECK_EN
  logic        misalign_err;
`endif

  ysyx_22040237_ifu dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
`ifdef YSYX_22040237_IFU_MISALIGN_CHECK_EN
    .misalign_err    (misalign_err),
`endif
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .pc              (pc),
    .inst            (inst)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int handshakes = 0;

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Instruction memory contents as a pure function of address.
  function automatic logic [31:0] mem_word(input logic [63:0] a);
    if (a == RST_PC) return 32'h0000_0413;
    return a[31:0] ^ a[63:32] ^ 32'h1357_0013;
  endfunction

  // Memory model knobs (written by the main sequence).
  int          ready_mode = 0;   // 0: always ready, 1: random, 2: never
  int          lat_mode = 0;     // 0: fixed mem_lat, 1: random 1..3
  int          mem_lat = 1;
  bit          ovr_en = 1'b0;
  logic [31:0] ovr_data = 32'h0;
  bit          spurious_en = 1'b0;

  bit          outst = 1'b0;
  int          cnt = 0;
  logic [63:0] outst_addr = 64'h0;

  // Memory: responds mem_lat cycles after accepting; keeps running through reset.
  initial begin
    forever begin
      @(negedge clk);
      #0.5;
      imem_resp_valid = 1'b0;
      if (outst) begin
        cnt--;
        if (cnt == 0) begin
          imem_resp_valid = 1'b1;
          imem_resp_data  = ovr_en ? ovr_data : mem_word(outst_addr);
          ovr_en = 1'b0;
          outst  = 1'b0;
        end
      end else if (spurious_en && $urandom_range(7) == 0) begin
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'hBAD0_0BAD;
      end
      case (ready_mode)
        0:       imem_req_ready = 1'b1;
        1:       imem_req_ready = ($urandom_range(1) == 1);
        default: imem_req_ready = 1'b0;
      endcase
      #0.5;
      if (rst_n && imem_req_valid && imem_req_ready) begin
        checks++;
        if (outst) begin
          errors++;
          $display("FAIL one_outstanding actual=second_request required=none addr=%h", imem_req_addr);
        end
        outst      = 1'b1;
        outst_addr = imem_req_addr;
        cnt        = (lat_mode != 0) ? int'($urandom_range(1, 3)) : mem_lat;
      end
    end
  end

  // Program-order model: next delivered pc is previous+4, or the latest jump target.
  logic [63:0] exp_q[$];
  bit          prev_hold = 1'b0;
  bit          prev_req = 1'b0;
  logic [63:0] prev_pc = 64'h0;
  logic [31:0] prev_inst = 32'h0;
  logic [63:0] prev_addr = 64'h0;

  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        prev_hold = 1'b0;
        prev_req  = 1'b0;
      end else begin
        if (prev_hold) begin
          check64("hold_valid", {63'b0, inst_valid}, 64'd1);
          check64("hold_pc", pc, prev_pc);
          check64("hold_inst", {32'b0, inst}, {32'b0, prev_inst});
        end
        if (prev_req) begin
          check64("req_valid_held", {63'b0, imem_req_valid}, 64'd1);
          check64("req_addr_stable", imem_req_addr, prev_addr);
        end
        if (inst_valid && inst_ready) begin
          logic [63:0] e;
          handshakes++;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL deliver_unexpected actual_pc=%h required=no_delivery", pc);
          end else begin
            e = exp_q.pop_front();
            check64("deliver_pc", pc, e);
            check64("deliver_inst", {32'b0, inst}, {32'b0, mem_word(e)});
            if (!redirect_valid) exp_q.push_back(e + 64'd4);
          end
        end
        if (redirect_valid) begin
          exp_q.delete();
          exp_q.push_back(redirect_pc & ~64'h3);
        end
        prev_hold = inst_valid && !inst_ready && !redirect_valid;
        prev_req  = imem_req_valid && !imem_req_ready && !redirect_valid;
        prev_pc   = pc;
        prev_inst = inst;
        prev_addr = imem_req_addr;
      end
    end
  end

  task automatic wait_req(input string name, input logic [63:0] exp);
    int n = 0;
    while (!imem_req_valid && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!imem_req_valid) begin
      checks++;
      errors++;
      $display("FAIL %s actual=timeout required=request_at_%h", name, exp);
    end else begin
      check64(name, imem_req_addr, exp);
    end
  endtask

  task automatic wait_ivalid(input string name);
    int n = 0;
    while (!inst_valid && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    checks++;
    if (!inst_valid) begin
      errors++;
      $display("FAIL %s actual=timeout required=inst_valid", name);
    end
  endtask

  initial begin
    logic [63:0] t;
    int hs_start;
    exp_q.push_back(RST_PC);
    repeat (3) @(negedge clk);
    #1;
    check64("rst_req_valid", {63'b0, imem_req_valid}, 64'd0);
    check64("rst_req_addr", imem_req_addr, RST_PC);
    check64("rst_inst_valid", {63'b0, inst_valid}, 64'd0);
    check64("rst_pc", pc, RST_PC);
    check64("rst_inst", {32'b0, inst}, {32'b0, NOP});

    // First fetch with single-cycle memory.
    @(negedge clk);
    rst_n = 1'b1;
    inst_ready = 1'b1;
    #1;
    check64("idle_no_req", {63'b0, imem_req_valid}, 64'd0);
    wait_req("t1_first_addr", RST_PC);
    wait_ivalid("t1_inst_valid");
    check64("t1_pc", pc, RST_PC);
    check64("t1_inst", {32'b0, inst}, 64'h0000_0413);
    @(negedge clk);
    inst_ready = 1'b0;
    #1;
    wait_req("t1_next_addr", RST_PC + 64'd4);

    // Back-pressure from decode for five cycles.
    wait_ivalid("t2_inst_valid");
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      #1;
      check64("t2_valid", {63'b0, inst_valid}, 64'd1);
      check64("t2_pc", pc, RST_PC + 64'd4);
      check64("t2_inst", {32'b0, inst}, {32'b0, mem_word(RST_PC + 64'd4)});
      check64("t2_no_req", {63'b0, imem_req_valid}, 64'd0);
    end
    mem_lat  = 2;
    ovr_data = 32'hDEAD_BEEF;
    ovr_en   = 1'b1;
    @(negedge clk);
    inst_ready = 1'b1;
    #1;
    @(negedge clk);
    inst_ready = 1'b0;
    #1;

    // Redirect while waiting; the in-flight response must be dropped.
    wait_req("t3_seq_addr", RST_PC + 64'd8);
    @(negedge clk);
    mem_lat = 1;
    redirect_valid = 1'b1;
    redirect_pc = 64'h0000_0000_8000_0100;
    #1;
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    @(negedge clk);
    #1;
    check64("t3_no_inst_valid", {63'b0, inst_valid}, 64'd0);
    wait_req("t3_redirect_addr", 64'h0000_0000_8000_0100);

    // Redirect in HOLD together with consume.
    wait_ivalid("t4_inst_valid");
    check64("t4_pc", pc, 64'h0000_0000_8000_0100);
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc = 64'h0000_0000_8000_0200;
    inst_ready = 1'b1;
    ready_mode = 2;
    #1;
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    wait_req("t4_redirect_addr", 64'h0000_0000_8000_0200);

    // Memory stalls the request for three cycles, accepts on the fourth.
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      #1;
      check64("t5_valid_held", {63'b0, imem_req_valid}, 64'd1);
      check64("t5_addr_held", imem_req_addr, 64'h0000_0000_8000_0200);
    end
    @(negedge clk);
    ready_mode = 0;
    mem_lat = 3;
    #1;
    check64("t5_valid_accept", {63'b0, imem_req_valid}, 64'd1);
    @(negedge clk);
    #1;
    check64("t5_wait_no_req", {63'b0, imem_req_valid}, 64'd0);

    // Reset mid-fetch; the late response must be ignored.
    wait_ivalid("t6_prev_inst");
    @(negedge clk);
    #1;
    wait_req("t6_pre_addr", 64'h0000_0000_8000_0204);
    @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    exp_q.push_back(RST_PC);
    #1;
    check64("t6_rst_req_valid", {63'b0, imem_req_valid}, 64'd0);
    check64("t6_rst_req_addr", imem_req_addr, RST_PC);
    check64("t6_rst_inst_valid", {63'b0, inst_valid}, 64'd0);
    check64("t6_rst_pc", pc, RST_PC);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    wait_req("t6_first_addr", RST_PC);
    wait_ivalid("t6_inst_valid");
    check64("t6_pc", pc, RST_PC);
    check64("t6_inst", {32'b0, inst}, 64'h0000_0413);
    @(negedge clk);
    #1;

    // Random memory timing, decode stalls, spurious responses and jumps.
    mem_lat = 1;
    ready_mode = 1;
    lat_mode = 1;
    spurious_en = 1'b1;
    hs_start = handshakes;
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      inst_ready = ($urandom_range(3) != 0);
      if ($urandom_range(15) == 0) begin
        t = {32'h0, $urandom()};
        case ($urandom_range(2))
          0:       t = RST_PC + (t & 64'hFFC);
          1:       t = 64'hFFFF_FFFF_FFFF_FFF0 + (t & LOW_MASK);
          default: t = {t[31:0], 32'h0} | (t & LOW_MASK);
        endcase
        redirect_valid = 1'b1;
        redirect_pc = t;
      end else begin
        redirect_valid = 1'b0;
      end
    end
    @(negedge clk);
    redirect_valid = 1'b0;
    inst_ready = 1'b1;
    repeat (10) @(negedge clk);
    #1;
    checks++;
    if (handshakes - hs_start < 40) begin
      errors++;
      $display("FAIL random_progress actual=%0d required>=40", handshakes - hs_start);
    end
`ifdef YSYX_22040237_IFU_MISALIGN_CHECK_EN
    check64("misalign_clear", {63'b0, misalign_err}, 64'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
